// File: rtl/l2_arbiter_pkg.sv
// lc3b_types: shared types for the L2 front end.
//   lc3b_line      - one 128-bit cache line
//   lc3b_line_adr  - 12-bit line address
//   lc3b_line_sel  - 16-bit byte select for a line
//   l2_arb_state_t - l2_arbiter FSM state
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_adr;
  typedef logic [15:0]  lc3b_line_sel;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } l2_arb_state_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// wishbone: line-wide Wishbone bus between the caches, the arbiter and the L2.
//   CLK              - bus clock (same as the system clock)
//   ADR/DAT_M/WE/SEL - request, driven by the master
//   STB/CYC          - request strobe / cycle valid, driven by the master
//   DAT_S/ACK/RTY    - response, driven by the slave
interface wishbone (input logic CLK);
  import lc3b_types::*;

  lc3b_line_adr ADR;
  lc3b_line     DAT_M;
  lc3b_line     DAT_S;
  logic         WE;
  lc3b_line_sel SEL;
  logic         STB;
  logic         CYC;
  logic         ACK;
  logic         RTY;

  modport master (
    output ADR, DAT_M, WE, SEL, STB, CYC,
    input  DAT_S, ACK
  );

  modport slave (
    input  ADR, DAT_M, WE, SEL, STB, CYC,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/l2_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker (combinational).
//   req_i, req_d     - pending requests
//   last             - 0 = I served last, 1 = D served last
//   grant_i, grant_d - one-hot grant, or zero when nothing is requested
module rr_pick2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic grant_i,
  output logic grant_d
);

  // On a tie the port that was not served last wins.
  assign grant_i = req_i & (~req_d | last);
  assign grant_d = req_d & (~req_i | ~last);

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter of the I-cache and D-cache miss paths onto
// the single L2 Wishbone slave.
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   wb_i  - I-cache side (slave port)
//   wb_d  - D-cache side (slave port)
//   wb_l2 - toward the L2 (master port)
//
// state  | meaning
// IDLE   | no L2 transaction; arbitrate pending requests
// BUSY_I | latched I-cache request presented to the L2
// BUSY_D | latched D-cache request presented to the L2
module l2_arbiter
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    rst,
  wishbone.slave  wb_i,
  wishbone.slave  wb_d,
  wishbone.master wb_l2
);

  l2_arb_state_t state, state_nxt;
  logic          last;
  lc3b_line_adr  adr_q;
  lc3b_line      dat_q;
  logic          we_q;
  lc3b_line_sel  sel_q;

  logic req_i, req_d;
  logic grant_i, grant_d;
  logic ack_i, ack_d;

  assign req_i = wb_i.STB & wb_i.CYC;
  assign req_d = wb_d.STB & wb_d.CYC;

  rr_pick2 u_pick (
    .req_i   (req_i),
    .req_d   (req_d),
    .last    (last),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The ACK cycle always returns to IDLE, so a request still held then is
  // only re-arbitrated one cycle later.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (wb_l2.ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and round-robin history; the L2 only ever sees these, so a
  // requester changing or withdrawing its bus cannot disturb the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= 1'b1;
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_i) begin
          adr_q <= wb_i.ADR;
          dat_q <= wb_i.DAT_M;
          we_q  <= wb_i.WE;
          sel_q <= wb_i.SEL;
        end else if (grant_d) begin
          adr_q <= wb_d.ADR;
          dat_q <= wb_d.DAT_M;
          we_q  <= wb_d.WE;
          sel_q <= wb_d.SEL;
        end
      end
      if (state == BUSY_I && wb_l2.ACK) last <= 1'b0;
      if (state == BUSY_D && wb_l2.ACK) last <= 1'b1;
    end
  end

  always_comb begin
    wb_l2.STB   = (state != IDLE);
    wb_l2.CYC   = (state != IDLE);
    wb_l2.ADR   = adr_q;
    wb_l2.DAT_M = dat_q;
    wb_l2.WE    = we_q;
    wb_l2.SEL   = sel_q;

    // An ACK for a withdrawn owner is swallowed here.
    ack_i = (state == BUSY_I) & wb_l2.ACK & req_i;
    ack_d = (state == BUSY_D) & wb_l2.ACK & req_d;

    wb_i.ACK   = ack_i;
    wb_d.ACK   = ack_d;
    wb_i.RTY   = req_i & ~ack_i;
    wb_d.RTY   = req_d & ~ack_d;
    wb_i.DAT_S = (state == BUSY_I) ? wb_l2.DAT_S : '0;
    wb_d.DAT_S = (state == BUSY_D) ? wb_l2.DAT_S : '0;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  localparam logic [11:0]  ADR_I  = 12'h0A3;
  localparam logic [11:0]  ADR_D  = 12'h155;
  localparam logic [127:0] L2_DAT = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] D_DAT  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] D_ALT  = 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555;
  localparam logic [127:0] I_DAT  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wishbone wb_i  (.CLK(clk));
  wishbone wb_d  (.CLK(clk));
  wishbone wb_l2 (.CLK(clk));

  l2_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .wb_i  (wb_i.slave),
    .wb_d  (wb_d.slave),
    .wb_l2 (wb_l2.master)
  );

  typedef struct {
    bit          ri, rd, ak;
    bit          stb;
    logic [11:0] adr;
    bit          we, ai, ad, yi, yd;
    logic [1:0]  own;   // 0 none, 1 I, 2 D
  } vec_t;

  vec_t vecs[13];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit ri, rd, ak, stb, input logic [11:0] adr,
                              input bit we, ai, ad, yi, yd, input logic [1:0] own);
    vec_t v;
    v.ri = ri; v.rd = rd; v.ak = ak; v.stb = stb; v.adr = adr; v.we = we;
    v.ai = ai; v.ad = ad; v.yi = yi; v.yd = yd; v.own = own;
    return v;
  endfunction

  task automatic drive(input bit ri, input bit rd, input bit ak);
    wb_i.STB  = ri; wb_i.CYC = ri;
    wb_d.STB  = rd; wb_d.CYC = rd;
    wb_l2.ACK = ak;
  endtask

  initial begin
    //               ri rd ak stb adr    we ai ad yi yd own
    vecs[0]  = mk(H, H, L, L, 12'h000, L, L, L, H, H, 2'd0);
    vecs[1]  = mk(H, H, L, H, ADR_I,   L, L, L, H, H, 2'd1);
    vecs[2]  = mk(H, H, H, H, ADR_I,   L, H, L, L, H, 2'd1);
    vecs[3]  = mk(H, H, L, L, ADR_I,   L, L, L, H, H, 2'd0);
    vecs[4]  = mk(H, H, H, H, ADR_D,   H, L, H, H, L, 2'd2);
    vecs[5]  = mk(H, H, L, L, ADR_D,   H, L, L, H, H, 2'd0);
    vecs[6]  = mk(H, L, L, H, ADR_I,   L, L, L, H, L, 2'd1);
    vecs[7]  = mk(L, L, L, H, ADR_I,   L, L, L, L, L, 2'd1);
    vecs[8]  = mk(L, L, H, H, ADR_I,   L, L, L, L, L, 2'd1);
    vecs[9]  = mk(L, L, H, L, ADR_I,   L, L, L, L, L, 2'd0);
    vecs[10] = mk(L, H, L, L, ADR_I,   L, L, L, L, H, 2'd0);
    vecs[11] = mk(L, H, L, H, ADR_D,   H, L, L, L, H, 2'd2);
    vecs[12] = mk(L, H, H, H, ADR_D,   H, L, H, L, L, 2'd2);

    wb_i.ADR = ADR_I; wb_i.DAT_M = I_DAT; wb_i.WE = 1'b0; wb_i.SEL = 16'hFFFF;
    wb_d.ADR = ADR_D; wb_d.DAT_M = D_DAT; wb_d.WE = 1'b1; wb_d.SEL = 16'hFFFF;
    wb_l2.DAT_S = L2_DAT; wb_l2.RTY = 1'b0;
    drive(L, L, L);

    #1;
    chk("rst_stb",   wb_l2.STB, 1'b0);
    chk("rst_cyc",   wb_l2.CYC, 1'b0);
    chk("rst_adr",   wb_l2.ADR, 12'h000);
    chk("rst_sel",   wb_l2.SEL, 16'h0000);
    chk("rst_we",    wb_l2.WE, 1'b0);
    chk("rst_ack_i", wb_i.ACK, 1'b0);
    chk("rst_dat_d", wb_d.DAT_S, 128'h0);
    wb_i.STB = 1'b1; wb_i.CYC = 1'b1;
    #1;
    chk("rst_rty_i", wb_i.RTY, 1'b1);
    drive(L, L, L);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table: tie from reset, alternation, withdrawn owner, ACK in IDLE.
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].ri, vecs[k].rd, vecs[k].ak);
      #1;
      chk($sformatf("v%0d_stb", k),   wb_l2.STB, vecs[k].stb);
      chk($sformatf("v%0d_cyc", k),   wb_l2.CYC, vecs[k].stb);
      chk($sformatf("v%0d_adr", k),   wb_l2.ADR, vecs[k].adr);
      chk($sformatf("v%0d_we", k),    wb_l2.WE, vecs[k].we);
      chk($sformatf("v%0d_ack_i", k), wb_i.ACK, vecs[k].ai);
      chk($sformatf("v%0d_ack_d", k), wb_d.ACK, vecs[k].ad);
      chk($sformatf("v%0d_rty_i", k), wb_i.RTY, vecs[k].yi);
      chk($sformatf("v%0d_rty_d", k), wb_d.RTY, vecs[k].yd);
      chk($sformatf("v%0d_dat_i", k), wb_i.DAT_S, (vecs[k].own == 2'd1) ? L2_DAT : 128'h0);
      chk($sformatf("v%0d_dat_d", k), wb_d.DAT_S, (vecs[k].own == 2'd2) ? L2_DAT : 128'h0);
      if (vecs[k].stb) chk($sformatf("v%0d_sel", k), wb_l2.SEL, 16'hFFFF);
      @(negedge clk);
    end
    drive(L, L, L);
    @(negedge clk);

    // D write data held while the D-cache changes DAT_M mid-transaction.
    drive(L, H, L);
    @(negedge clk);
    wb_d.DAT_M = D_ALT;
    #1;
    chk("hold_stb", wb_l2.STB, 1'b1);
    chk("hold_dat0", wb_l2.DAT_M, D_DAT);
    chk("hold_we", wb_l2.WE, 1'b1);
    @(negedge clk);
    chk("hold_dat1", wb_l2.DAT_M, D_DAT);
    wb_l2.ACK = 1'b1;
    #1;
    chk("hold_ack_d", wb_d.ACK, 1'b1);
    chk("hold_dat2", wb_l2.DAT_M, D_DAT);
    @(negedge clk);
    drive(L, L, L);
    wb_d.DAT_M = D_DAT;
    #1;
    chk("hold_idle", wb_l2.STB, 1'b0);
    @(negedge clk);

    // I-only read, L2 ACKs in the third busy cycle.
    drive(H, L, L);
    #1;
    chk("rd_n_stb", wb_l2.STB, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      wb_l2.ACK = (c == 3);
      #1;
      chk($sformatf("rd_c%0d_stb", c), wb_l2.STB, 1'b1);
      chk($sformatf("rd_c%0d_adr", c), wb_l2.ADR, ADR_I);
      chk($sformatf("rd_c%0d_we", c), wb_l2.WE, 1'b0);
      chk($sformatf("rd_c%0d_ack_i", c), wb_i.ACK, (c == 3));
      chk($sformatf("rd_c%0d_ack_d", c), wb_d.ACK, 1'b0);
    end
    chk("rd_dat_i", wb_i.DAT_S, L2_DAT);
    @(negedge clk);
    drive(L, L, L);
    @(negedge clk);

    // Reset pulse during BUSY_D abandons the transaction; I wins the next tie.
    drive(L, H, L);
    @(negedge clk);
    #1;
    chk("rb_busy", wb_l2.STB, 1'b1);
    rst = 1'b1;
    #1;
    chk("rb_stb", wb_l2.STB, 1'b0);
    chk("rb_cyc", wb_l2.CYC, 1'b0);
    chk("rb_adr", wb_l2.ADR, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    drive(H, H, L);
    @(negedge clk);
    #1;
    chk("rb_tie_stb", wb_l2.STB, 1'b1);
    chk("rb_tie_adr", wb_l2.ADR, ADR_I);
    drive(L, L, L);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-master to one-slave Wishbone arbiter sitting directly upstream of the L2 cache. It accepts line requests from the I-cache and D-cache miss paths and grants one at a time using round-robin. The winning request is latched and presented to the L2 slave port, and the L2 response is returned to the owner. Request signals seen by the L2 stay stable for the whole transaction, even if a requester withdraws.

## Interface
Parameters: none. Widths come from the `wishbone` interface: ADR 12 (line address), DAT 128, SEL 16.

Ports:
- `clk`  in  1  system clock; same clock as `CLK` on all three interfaces.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_i`  `wishbone.slave`  –  I-cache side. Drives `DAT_S`, `ACK`, `RTY`; reads `ADR`, `DAT_M`, `WE`, `SEL`, `STB`, `CYC`.
- `wb_d`  `wishbone.slave`  –  D-cache side. Same signals as `wb_i`.
- `wb_l2`  `wishbone.master`  –  toward the L2. Drives `ADR`, `DAT_M`, `WE`, `SEL`, `STB`, `CYC`; reads `DAT_S`, `ACK`.

## Operation
- A request on port x is `req_x = STB & CYC`.
- State machine has three states: `IDLE`, `BUSY_I`, `BUSY_D`.
- Registers:
  - `last`: 0 = I served last, 1 = D served last.
  - Latched `ADR` (12), `DAT_M` (128), `WE` (1), `SEL` (16).
- `IDLE`:
  - Only `req_i` → latch I request, go to `BUSY_I`.
  - Only `req_d` → latch D request, go to `BUSY_D`.
  - Both → grant I if `last` = 1, else D.
  - Neither → stay in `IDLE`.
- `BUSY_x`:
  - `wb_l2.STB` = `wb_l2.CYC` = 1.
  - `wb_l2.ADR`, `DAT_M`, `WE`, `SEL` come from the latched registers only.
  - On `wb_l2.ACK`: set `last` to x, go to `IDLE`.
- Response routing (combinational):
  - `wb_x.ACK = (state == BUSY_x) & wb_l2.ACK & req_x`.
  - `wb_x.DAT_S = wb_l2.DAT_S` when x is the owner, else 0.
- `wb_x.RTY = req_x & ~wb_x.ACK`, matching the L2 retry convention.
- Withdrawn owner: if the owner drops `req_x` while in `BUSY_x`, the L2 transaction still runs to its ACK. That ACK is discarded (not forwarded), then the FSM returns to `IDLE`.
- The non-owner port sees `RTY` for its whole wait. It is never ACKed on another port's transaction.
- Pending request at ACK: a request still asserted on the ACK cycle is not re-granted in that cycle. The one `IDLE` cycle lets the owner drop `STB` first.

## Timing
- Reset (async, immediate): state = `IDLE`, `last` = 1 (I wins the first tie), latched registers = 0.
- Outputs under reset: `wb_l2.STB/CYC/WE` = 0, `wb_l2.ADR` = 0, `wb_l2.SEL` = 0, all slave `ACK` and `DAT_S` = 0. `RTY` follows `req_x`.
- Request latency: a request seen in `IDLE` in cycle n makes `wb_l2.STB` high in cycle n+1.
- Response latency: 0 cycles; slave `ACK` is in the same cycle as `wb_l2.ACK`.
- Turnaround: at least one `IDLE` cycle between consecutive L2 transactions, so back-to-back throughput is one transaction per (L2 latency + 2) cycles.
- Reset asserted mid-transaction: `STB/CYC` to the L2 drop asynchronously and the transaction is abandoned. The L2 is reset by the same `rst`.
- `wb_l2.ACK` while in `IDLE` is ignored.

## Structure
- `lc3b_types`: add `l2_arb_state_t` enum (`IDLE`, `BUSY_I`, `BUSY_D`).
- `lc3b_types`: add `lc3b_line` (128-bit) and `lc3b_line_adr` (12-bit) typedefs if not already present.
- Sub-module `rr_pick2`: combinational round-robin picker. Inputs `req_i`, `req_d`, `last`; outputs `grant_i`, `grant_d`, one-hot or zero.
- Top level holds the FSM, the latch registers and the response muxing.

## Test plan
- I-cache only reads `ADR`=12'h0A3 and the L2 ACKs 3 cycles later with `DAT_S`=128'hDEAD…BEEF → `wb_l2.ADR`=0A3 and `WE`=0 from cycle 1; `wb_i.ACK` with that data; `wb_d.ACK` never asserts.
- I and D request together from reset → I granted first. After I's ACK and one `IDLE` cycle, D is granted with its `ADR`/`DAT_M`/`WE`=1/`SEL`=FFFF. Both requests held again → I is granted next (alternation).
- D write with `DAT_M`=128'h1234…; D changes its `DAT_M` mid-transaction → `wb_l2.DAT_M` stays 128'h1234… until ACK.
- I request granted; I drops `CYC` after 1 cycle; L2 ACKs 4 cycles later → no `wb_i.ACK`, FSM returns to `IDLE`, next request granted normally.
- `rst` pulsed while in `BUSY_D` → `wb_l2.STB/CYC` go 0 in the same cycle; after release, a simultaneous I+D request grants I.
